// File: rtl/ram_pkg.sv
// Shared types for the PUF capture RAM and its sequencer.
package ram_pkg;
  localparam int RAM_ADDR_WIDTH = 6;
  localparam int RAM_DATA_WIDTH = 8;

  typedef logic [RAM_ADDR_WIDTH-1:0] ram_addr_t;
  typedef logic [RAM_DATA_WIDTH-1:0] ram_data_t;
endpackage

// File: rtl/ram_sp_64x8.sv
// Single-port 64x8 synchronous RAM, registered output, write-through on
// read-during-write, synchronous active-low reset of the output only.
module ram_sp_64x8
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  output logic [DATA_WIDTH-1:0] q
);

  // No reset on the array: contents must survive reset for PUF capture.
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_q;
  logic                  w_we;

  assign w_we = rst & wren;

  always_ff @(posedge clock) begin
    if (w_we) mem[address] <= data;
  end

  always_ff @(posedge clock) begin
    if (!rst)      r_q <= '0;
    else if (wren) r_q <= data;
    else           r_q <= mem[address];
  end

  assign q = r_q;

endmodule

// File: tb/tb_ram_sp_64x8.sv
// Directed self-checking bench for ram_sp_64x8.
module tb_ram_sp_64x8;
  import ram_pkg::*;

  logic      clock = 1'b0;
  logic      rst   = 1'b1;
  ram_addr_t address = '0;
  ram_data_t data    = '0;
  logic      wren    = 1'b0;
  ram_data_t q;

  int n_run  = 0;
  int n_fail = 0;

  ram_sp_64x8 dut (
    .clock   (clock),
    .rst     (rst),
    .address (address),
    .data    (data),
    .wren    (wren),
    .q       (q)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input ram_data_t got, input ram_data_t exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs away from the edge, then sample just after it.
  task automatic cyc(input logic r, input logic we, input int a, input int d);
    @(negedge clock);
    rst     = r;
    wren    = we;
    address = ram_addr_t'(a);
    data    = ram_data_t'(d);
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Seed address 5 so the suppressed-write check has a known value.
    cyc(1'b1, 1'b1, 5, 8'h5A);
    chk("seed_wt", q, 8'h5A);

    // 1. Reset with a pending write of FF to address 5
    cyc(1'b0, 1'b1, 5, 8'hFF);
    chk("rst_q0", q, 8'h00);
    cyc(1'b0, 1'b1, 5, 8'hFF);
    chk("rst_q1", q, 8'h00);
    cyc(1'b1, 1'b0, 5, 0);
    chk("rst_nowr", q, 8'h5A);

    // 2. Sequential fill then readback
    for (int a = 0; a < 64; a++) begin
      cyc(1'b1, 1'b1, a, a ^ 8'hA5);
      if (a == 0 || a == 63) chk("fill_wt", q, ram_data_t'(a ^ 8'hA5));
    end
    for (int a = 0; a < 64; a++) begin
      cyc(1'b1, 1'b0, a, 0);
      chk($sformatf("rd%0d", a), q, ram_data_t'(a ^ 8'hA5));
    end

    // 3. Read-during-write
    cyc(1'b1, 1'b1, 10, 8'h11);
    cyc(1'b1, 1'b0, 10, 0);
    chk("rdw_pre", q, 8'h11);
    cyc(1'b1, 1'b1, 10, 8'h22);
    chk("rdw_new", q, 8'h22);
    cyc(1'b1, 1'b0, 10, 0);
    chk("rdw_rd", q, 8'h22);

    // 4. Reset preserves contents
    cyc(1'b1, 1'b1, 63, 8'h3C);
    cyc(1'b0, 1'b0, 63, 0);
    chk("rstp_q0", q, 8'h00);
    cyc(1'b1, 1'b0, 63, 0);
    chk("rstp_rd", q, 8'h3C);

    // 5. Boundary addresses, no aliasing
    cyc(1'b1, 1'b1, 63, 8'h01);
    cyc(1'b1, 1'b1, 0,  8'h02);
    cyc(1'b1, 1'b0, 63, 0);
    chk("wrap63", q, 8'h01);
    cyc(1'b1, 1'b0, 0, 0);
    chk("wrap0", q, 8'h02);

    // 6. Reset mid-stream drops only the write on the reset edge
    cyc(1'b1, 1'b1, 20, 8'hC0);
    cyc(1'b0, 1'b1, 21, 8'hC1);
    chk("mid_q0", q, 8'h00);
    cyc(1'b1, 1'b1, 22, 8'hC2);
    chk("mid_wt", q, 8'hC2);
    cyc(1'b1, 1'b0, 20, 0);
    chk("mid20", q, 8'hC0);
    cyc(1'b1, 1'b0, 21, 0);
    chk("mid21", q, ram_data_t'(21 ^ 8'hA5));
    cyc(1'b1, 1'b0, 22, 0);
    chk("mid22", q, 8'hC2);

    // q holds between edges
    @(negedge clock);
    chk("hold", q, 8'hC2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
